// File: rtl/mem_stage_ctrl.sv
// MEM-stage memory sequencer for the LC-3b pipeline: single accesses,
// LDI/STI indirection, byte lane formatting and pipeline stall.
module mem_stage_ctrl #(
  parameter int WIDTH      = 16,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [3:0]       opcode,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [WIDTH-1:0] addr_in,
  input  logic [WIDTH-1:0] wdata_in,
  output logic [WIDTH-1:0] dmem_address,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [1:0]       dmem_byte_enable,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic [WIDTH-1:0] dmem_rdata,
  input  logic             dmem_resp,
  output logic [WIDTH-1:0] rdata_out,
  output logic             done,
  output logic             stall
);

  localparam logic [3:0] OP_LDB = 4'b0010;
  localparam logic [3:0] OP_STB = 4'b0011;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACC1,
    GAP,
    ACC2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] ptr;
  logic [CW-1:0]    gap_cnt;
  logic             mem_op;
  logic             is_ldb;
  logic             is_stb;
  logic             is_sti;
  logic             indirect;
  logic             acc1_wr;
  logic             gap_last;
  logic [7:0]       rbyte;

  assign mem_op   = in_valid & (mem_read | mem_write);
  assign is_ldb   = (opcode == OP_LDB);
  assign is_stb   = (opcode == OP_STB);
  assign is_sti   = (opcode == OP_STI);
  assign indirect = (opcode == OP_LDI) | is_sti;
  // indirection always starts with a pointer read
  assign acc1_wr  = mem_write & ~indirect;
  assign gap_last = (gap_cnt == CW'(GAP_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      gap_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == ACC1 && dmem_resp && indirect)
        ptr <= dmem_rdata;
      if (state == GAP && !gap_last)
        gap_cnt <= gap_cnt + CW'(1);
      else
        gap_cnt <= '0;
    end
  end

  assign rbyte = addr_in[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];

  always_comb begin
    rdata_out = dmem_rdata;
    if (is_ldb)
      rdata_out = {{(WIDTH-8){1'b0}}, rbyte};
  end

  always_comb begin
    state_nx         = state;
    dmem_address     = '0;
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_byte_enable = 2'b11;
    dmem_wdata       = '0;
    done             = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_op)
          state_nx = ACC1;
      end
      ACC1: begin
        dmem_address = addr_in;
        unique case (1'b1)
          acc1_wr && is_stb: begin
            dmem_write       = 1'b1;
            dmem_byte_enable = addr_in[0] ? 2'b10 : 2'b01;
            dmem_wdata       = {(WIDTH/8){wdata_in[7:0]}};
          end
          acc1_wr && !is_stb: begin
            dmem_write = 1'b1;
            dmem_wdata = wdata_in;
          end
          default: dmem_read = 1'b1;
        endcase
        if (dmem_resp) begin
          if (indirect) begin
            state_nx = GAP;
          end else begin
            done     = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_last)
          state_nx = ACC2;
      end
      ACC2: begin
        dmem_address = ptr;
        if (is_sti) begin
          dmem_write = 1'b1;
          dmem_wdata = wdata_in;
        end else begin
          dmem_read = 1'b1;
        end
        if (dmem_resp) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    // reset drops any in-flight request without a done pulse
    if (reset) begin
      state_nx         = IDLE;
      dmem_address     = '0;
      dmem_read        = 1'b0;
      dmem_write       = 1'b0;
      dmem_byte_enable = 2'b11;
      dmem_wdata       = '0;
      done             = 1'b0;
    end
  end

  assign stall = mem_op & ~done & ~reset;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl.
// Inputs change 1ns after the rising edge; outputs are checked right after.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [3:0]  opcode;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] addr_in;
  logic [15:0] wdata_in;
  logic [15:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [1:0]  dmem_byte_enable;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata;
  logic        dmem_resp;
  logic [15:0] rdata_out;
  logic        done;
  logic        stall;

  int checks = 0;
  int errors = 0;

  mem_stage_ctrl #(.WIDTH(16), .GAP_CYCLES(1)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .opcode(opcode),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .addr_in(addr_in),
    .wdata_in(wdata_in),
    .dmem_address(dmem_address),
    .dmem_read(dmem_read),
    .dmem_write(dmem_write),
    .dmem_byte_enable(dmem_byte_enable),
    .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp),
    .rdata_out(rdata_out),
    .done(done),
    .stall(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_out(input string tag);
    chk({tag, " rd"}, 16'(dmem_read), 16'h0);
    chk({tag, " wr"}, 16'(dmem_write), 16'h0);
    chk({tag, " done"}, 16'(done), 16'h0);
  endtask

  task automatic op(input logic [3:0] opc, input logic rd, input logic wr,
                    input logic [15:0] a, input logic [15:0] wd);
    in_valid  = 1'b1;
    opcode    = opc;
    mem_read  = rd;
    mem_write = wr;
    addr_in   = a;
    wdata_in  = wd;
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    opcode     = 4'h0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    addr_in    = 16'h0;
    wdata_in   = 16'h0;
    dmem_rdata = 16'h0;
    dmem_resp  = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    idle_out("reset");
    chk("reset be", 16'(dmem_byte_enable), 16'h3);
    chk("reset addr", dmem_address, 16'h0);
    chk("reset wdata", dmem_wdata, 16'h0);
    chk("reset stall", 16'(stall), 16'h0);

    // LDR with response in the third request cycle
    op(4'b0110, 1'b1, 1'b0, 16'h1234, 16'h0);
    #1;
    chk("ldr idle stall", 16'(stall), 16'h1);
    chk("ldr idle rd", 16'(dmem_read), 16'h0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("ldr wait rd", 16'(dmem_read), 16'h1);
      chk("ldr wait addr", dmem_address, 16'h1234);
      chk("ldr wait done", 16'(done), 16'h0);
      chk("ldr wait stall", 16'(stall), 16'h1);
    end
    cyc();
    dmem_resp  = 1'b1;
    dmem_rdata = 16'hBEEF;
    #1;
    chk("ldr resp rd", 16'(dmem_read), 16'h1);
    chk("ldr resp done", 16'(done), 16'h1);
    chk("ldr resp data", rdata_out, 16'hBEEF);
    chk("ldr resp stall", 16'(stall), 16'h0);

    // STB odd then even address
    cyc();
    dmem_resp = 1'b0;
    op(4'b0011, 1'b0, 1'b1, 16'h2001, 16'h00A5);
    #1;
    idle_out("stb idle");
    cyc();
    dmem_resp = 1'b1;
    #1;
    chk("stb1 wr", 16'(dmem_write), 16'h1);
    chk("stb1 rd", 16'(dmem_read), 16'h0);
    chk("stb1 be", 16'(dmem_byte_enable), 16'h2);
    chk("stb1 wdata", dmem_wdata, 16'hA5A5);
    chk("stb1 addr", dmem_address, 16'h2001);
    chk("stb1 done", 16'(done), 16'h1);
    cyc();
    dmem_resp = 1'b0;
    op(4'b0011, 1'b0, 1'b1, 16'h2000, 16'h00A5);
    cyc();
    dmem_resp = 1'b1;
    #1;
    chk("stb0 be", 16'(dmem_byte_enable), 16'h1);
    chk("stb0 wdata", dmem_wdata, 16'hA5A5);

    // LDB high and low byte
    cyc();
    dmem_resp = 1'b0;
    op(4'b0010, 1'b1, 1'b0, 16'h3001, 16'h0);
    cyc();
    dmem_resp  = 1'b1;
    dmem_rdata = 16'h8F12;
    #1;
    chk("ldb1 be", 16'(dmem_byte_enable), 16'h3);
    chk("ldb1 data", rdata_out, 16'h008F);
    chk("ldb1 done", 16'(done), 16'h1);
    cyc();
    dmem_resp = 1'b0;
    op(4'b0010, 1'b1, 1'b0, 16'h3000, 16'h0);
    cyc();
    dmem_resp = 1'b1;
    #1;
    chk("ldb0 data", rdata_out, 16'h0012);

    // LDI with one gap cycle
    cyc();
    dmem_resp = 1'b0;
    op(4'b1010, 1'b1, 1'b0, 16'h4000, 16'h0);
    cyc();
    dmem_resp  = 1'b1;
    dmem_rdata = 16'h5000;
    #1;
    chk("ldi a1 rd", 16'(dmem_read), 16'h1);
    chk("ldi a1 addr", dmem_address, 16'h4000);
    chk("ldi a1 done", 16'(done), 16'h0);
    chk("ldi a1 stall", 16'(stall), 16'h1);
    cyc();
    dmem_rdata = 16'hDEAD;
    #1;
    idle_out("ldi gap");
    chk("ldi gap stall", 16'(stall), 16'h1);
    cyc();
    dmem_rdata = 16'h0042;
    #1;
    chk("ldi a2 rd", 16'(dmem_read), 16'h1);
    chk("ldi a2 addr", dmem_address, 16'h5000);
    chk("ldi a2 done", 16'(done), 16'h1);
    chk("ldi a2 data", rdata_out, 16'h0042);
    chk("ldi a2 stall", 16'(stall), 16'h0);

    // STI through pointer 0x6000
    cyc();
    dmem_resp = 1'b0;
    op(4'b1011, 1'b0, 1'b1, 16'h4000, 16'h1357);
    #1;
    idle_out("sti idle");
    cyc();
    dmem_resp  = 1'b1;
    dmem_rdata = 16'h6000;
    #1;
    chk("sti a1 rd", 16'(dmem_read), 16'h1);
    chk("sti a1 wr", 16'(dmem_write), 16'h0);
    chk("sti a1 done", 16'(done), 16'h0);
    cyc();
    idle_out("sti gap");
    cyc();
    chk("sti a2 wr", 16'(dmem_write), 16'h1);
    chk("sti a2 rd", 16'(dmem_read), 16'h0);
    chk("sti a2 addr", dmem_address, 16'h6000);
    chk("sti a2 wdata", dmem_wdata, 16'h1357);
    chk("sti a2 be", 16'(dmem_byte_enable), 16'h3);
    chk("sti a2 done", 16'(done), 16'h1);

    // word op with both read and write: write wins
    cyc();
    dmem_resp = 1'b0;
    op(4'b0111, 1'b1, 1'b1, 16'h7001, 16'hCAFE);
    cyc();
    chk("rw wr", 16'(dmem_write), 16'h1);
    chk("rw rd", 16'(dmem_read), 16'h0);
    chk("rw addr", dmem_address, 16'h7001);
    chk("rw wdata", dmem_wdata, 16'hCAFE);
    chk("rw be", 16'(dmem_byte_enable), 16'h3);
    dmem_resp = 1'b1;
    #1;
    chk("rw done", 16'(done), 16'h1);

    // reset while LDI is in its second access
    cyc();
    dmem_resp = 1'b0;
    op(4'b1010, 1'b1, 1'b0, 16'h4000, 16'h0);
    cyc();
    dmem_resp  = 1'b1;
    dmem_rdata = 16'h5000;
    cyc();
    dmem_resp = 1'b0;
    cyc();
    chk("rst acc2 rd", 16'(dmem_read), 16'h1);
    chk("rst acc2 addr", dmem_address, 16'h5000);
    reset = 1'b1;
    cyc();
    reset    = 1'b0;
    op(4'b0001, 1'b0, 1'b0, 16'h0, 16'h0);
    #1;
    idle_out("post rst");
    chk("post rst stall", 16'(stall), 16'h0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      idle_out("add");
      chk("add stall", 16'(stall), 16'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
